// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous circular FIFO: pointer sizing and parameter legality.
package fifo_pkg;

    localparam int MIN_DEPTH = 2;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int depth, input int afull, input int aempty);
        return (depth >= MIN_DEPTH) && is_pow2(depth) &&
               (afull >= 1) && (afull <= depth) &&
               (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// WIDTH x DEPTH storage with one synchronous write port and one asynchronous read port.
module fifo_sync_ram #(
    parameter int  WIDTH      = 8,
    parameter int  DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] waddr_in,
    input  logic [WIDTH-1:0]      wdata_in,
    input  logic [ADDR_WIDTH-1:0] raddr_in,
    output logic [WIDTH-1:0]      rdata_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset so it maps onto plain RAM; sequential writes use <= only.
    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem_q[waddr_in] <= wdata_in;
        end
    end

    assign rdata_out = mem_q[raddr_in];

endmodule

// File: rtl/fifo_sync_circular.sv
// Single-clock circular FIFO with occupancy, thresholds, sticky error flags and flush.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_sync_circular
    import fifo_pkg::*;
#(
    parameter int  DEPTH         = 16,
    parameter int  WIDTH         = 8,
    parameter int  AFULL_THRESH  = DEPTH - 2,
    parameter int  AEMPTY_THRESH = 2,
    localparam int PTR_WIDTH     = ptr_width(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush_in,
    input  logic                 write_in,
    input  logic [WIDTH-1:0]     data_write_in,
    input  logic                 read_in,
    output logic [WIDTH-1:0]     data_read_out,
    output logic                 valid_out,
    output logic                 full_out,
    output logic                 empty_out,
    output logic                 almost_full_out,
    output logic                 almost_empty_out,
    output logic [PTR_WIDTH-1:0] count_out,
    output logic                 overflow_out,
    output logic                 underflow_out
);

    localparam int ADDR_WIDTH = PTR_WIDTH - 1;
    localparam logic [PTR_WIDTH-1:0] AFULL_LVL  = PTR_WIDTH'(AFULL_THRESH);
    localparam logic [PTR_WIDTH-1:0] AEMPTY_LVL = PTR_WIDTH'(AEMPTY_THRESH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    if (!params_legal(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("fifo_sync_circular: illegal DEPTH or threshold parameters");
    end

    logic [PTR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic                 overflow_q, overflow_d, underflow_q, underflow_d;
    logic                 full, empty, wr_accept, rd_accept;
    logic [WIDTH-1:0]     ram_rdata;

    assign count     = wptr_q - rptr_q;
    assign full      = (wptr_q[PTR_WIDTH-1] != rptr_q[PTR_WIDTH-1]) &&
                       (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign empty     = (wptr_q == rptr_q);
    assign wr_accept = write_in && !full && !flush_in;
    assign rd_accept = read_in && !empty && !flush_in;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_in) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept)          wptr_d      = wptr_q + PTR_ONE;
            if (rd_accept)          rptr_d      = rptr_q + PTR_ONE;
            if (write_in && full)   overflow_d  = 1'b1;
            if (read_in && empty)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_in    (clk_in),
        .we_in     (wr_accept && !rst_in),
        .waddr_in  (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_in  (data_write_in),
        .raddr_in  (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_out (ram_rdata)
    );

`ifdef FIFO_SYNC_FWFT_EN
    assign data_read_out = ram_rdata;
    assign valid_out     = !empty;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;

    // Output register holds the last word read until the next accepted read.
    always_comb begin
        rdata_d = rdata_q;
        valid_d = rd_accept;
        if (rd_accept) rdata_d = ram_rdata;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign data_read_out = rdata_q;
    assign valid_out     = valid_q;
`endif

    assign full_out         = full;
    assign empty_out        = empty;
    assign count_out        = count;
    assign almost_full_out  = (count >= AFULL_LVL);
    assign almost_empty_out = (count <= AEMPTY_LVL);
    assign overflow_out     = overflow_q;
    assign underflow_out    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_circular.sv
// Scoreboard bench for fifo_sync_circular (DEPTH=16, WIDTH=8, thresholds 14/2).
module tb_fifo_sync_circular;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int PW    = 5;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             flush_in = 1'b0;
    logic             write_in = 1'b0;
    logic [WIDTH-1:0] data_write_in = '0;
    logic             read_in = 1'b0;
    logic [WIDTH-1:0] data_read_out;
    logic             valid_out, full_out, empty_out, almost_full_out, almost_empty_out;
    logic [PW-1:0]    count_out;
    logic             overflow_out, underflow_out;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    fifo_sync_circular #(
        .DEPTH         (DEPTH),
        .WIDTH         (WIDTH),
        .AFULL_THRESH  (14),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .flush_in         (flush_in),
        .write_in         (write_in),
        .data_write_in    (data_write_in),
        .read_in          (read_in),
        .data_read_out    (data_read_out),
        .valid_out        (valid_out),
        .full_out         (full_out),
        .empty_out        (empty_out),
        .almost_full_out  (almost_full_out),
        .almost_empty_out (almost_empty_out),
        .count_out        (count_out),
        .overflow_out     (overflow_out),
        .underflow_out    (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the expected word whenever the DUT hands one over.
    always @(negedge clk_in) begin
        logic take;
`ifdef FIFO_SYNC_FWFT_EN
        take = read_in && valid_out && !rst_in && !flush_in;
`else
        take = valid_out;
`endif
        if (take) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_data actual=0x%0h expected=none at %0t", data_read_out, $time);
            end else begin
                check("read_data", int'(data_read_out), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic f);
        write_in      = w;
        data_write_in = d;
        read_in       = r;
        flush_in      = f;
        @(posedge clk_in);
        #1;
        write_in = 1'b0;
        read_in  = 1'b0;
        flush_in = 1'b0;
    endtask

    task automatic check_levels(input string tag, input int n);
        check({tag, "_count"}, int'(count_out), n);
        check({tag, "_full"}, int'(full_out), int'(n == 16));
        check({tag, "_empty"}, int'(empty_out), int'(n == 0));
        check({tag, "_afull"}, int'(almost_full_out), int'(n >= 14));
        check({tag, "_aempty"}, int'(almost_empty_out), int'(n <= 2));
    endtask

    task automatic check_reset_state(input string tag);
        check_levels(tag, 0);
        check({tag, "_overflow"}, int'(overflow_out), 0);
        check({tag, "_underflow"}, int'(underflow_out), 0);
        check({tag, "_valid"}, int'(valid_out), 0);
`ifndef FIFO_SYNC_FWFT_EN
        check({tag, "_rdata"}, int'(data_read_out), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_reset_state("reset");

        // Fill 0x01..0x10, sweeping the threshold flags on the way up.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
            check_levels("fill", i + 1);
        end
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        check("ovf_set", int'(overflow_out), 1);
        check_levels("ovf", 16);
        check("ovf_no_udf", int'(underflow_out), 0);

        // Drain: data must be 0x01..0x10, 0x99 never stored.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(i + 1);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check_levels("drain", 15 - i);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_set", int'(underflow_out), 1);
        check("udf_valid", int'(valid_out), 0);
        check("udf_ovf_sticky", int'(overflow_out), 1);
        check_levels("udf", 0);

        // Prime to count 5, then 40 cycles of simultaneous read+write.
        for (int i = 0; i < 5; i++) cyc(1'b1, WIDTH'(8'h20 + i), 1'b0, 1'b0);
        check_levels("prime", 5);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'h20 + i);
            cyc(1'b1, WIDTH'(8'h25 + i), 1'b1, 1'b0);
            check("stream_count", int'(count_out), 5);
        end

        // Up to count 7, then flush with both accesses asserted.
        cyc(1'b1, 8'h50, 1'b0, 1'b0);
        cyc(1'b1, 8'h51, 1'b0, 1'b0);
        check_levels("preflush", 7);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        check_levels("flush", 0);
        check("flush_ovf", int'(overflow_out), 0);
        check("flush_udf", int'(underflow_out), 0);
        check("flush_valid", int'(valid_out), 0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        check_levels("postflush", 1);
        exp_q.push_back(8'h33);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_levels("postflush_rd", 0);

        // Reset in the middle of a burst with sticky flags set.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0);
        exp_q.push_back(8'hC0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("preburst_udf", int'(underflow_out), 1);
        rst_in        = 1'b1;
        write_in      = 1'b1;
        read_in       = 1'b1;
        data_write_in = 8'hEE;
        @(posedge clk_in);
        #1;
        rst_in   = 1'b0;
        write_in = 1'b0;
        read_in  = 1'b0;
        check_reset_state("midrst");
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_reset_state("midrst_idle");

        // Single word 0xA5: read-mode specific visibility.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
`ifdef FIFO_SYNC_FWFT_EN
        check("a5_fwft_data", int'(data_read_out), 8'hA5);
        check("a5_fwft_valid", int'(valid_out), 1);
        exp_q.push_back(8'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("a5_fwft_valid_after", int'(valid_out), 0);
`else
        check("a5_std_valid_pre", int'(valid_out), 0);
        check("a5_std_data_pre", int'(data_read_out), 0);
        exp_q.push_back(8'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("a5_std_data", int'(data_read_out), 8'hA5);
        check("a5_std_valid", int'(valid_out), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("a5_std_valid_pulse", int'(valid_out), 0);
        check("a5_std_data_hold", int'(data_read_out), 8'hA5);
`endif

        repeat (2) @(posedge clk_in);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
